st7735_spi_rx: RTL and testbench

- Panel-side receiver for the 4-wire ST7735 SPI stream (cs, sclk, mosi, dc) emitted by the st7735 driver.
- Oversamples the SPI pins in the system clock domain and assembles bytes.
- Decodes CASET/RASET/RAMWR and emits one strobe per RGB565 pixel with its (x, y) address.
- Used as a synthesizable panel model/checker in loopback and as a bench scoreboard source.

---
 rtl/st7735_pkg.sv | 27 ++
 rtl/spi_byte_rx.sv | 154 +++++++++++++++
 rtl/st7735_spi_rx.sv | 256 +++++++++++++++++++++++++
 tb/tb_st7735_spi_rx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/st7735_pkg.sv
// ---------------------------------------------------------------------------
// st7735_pkg
// Shared definitions for the ST7735 SPI panel-side receiver:
//   - command opcodes decoded by the receiver (CASET, RASET, RAMWR)
//   - byte-level decode FSM state encoding
//   - RGB565 pixel layout (red in the high bits, sent high byte first)
// ---------------------------------------------------------------------------
package st7735_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CASET_P = 2'd1,
      ST_RASET_P = 2'd2,
      ST_RAMWR   = 2'd3
   } rx_state_e;

   typedef struct packed {
      logic [4:0] red;
      logic [5:0] green;
      logic [4:0] blue;
   } rgb565_t;

endpackage : st7735_pkg

// File: rtl/spi_byte_rx.sv
// ---------------------------------------------------------------------------
// spi_byte_rx
// Oversampling SPI (mode 0, MSB first) byte receiver in the clk domain.
// Each pin passes through SYNC_STAGES flops; a rising edge of the
// synchronized SPI clock while chip select is low shifts in one bit and the
// 8th bit produces a one-cycle byte strobe.
//
// Optional macro ST7735_SPI_RX_STATS_EN adds the trunc_pulse output, a
// one-cycle strobe when chip select rises with a partial byte pending.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   spi_cs/clk/mosi/dc  raw SPI pins, asynchronous to clk
//   byte_valid          one-cycle strobe, byte received
//   byte_data, byte_dc  received byte and dc sampled with its 8th bit
//   trunc_pulse         (macro only) partial byte discarded by a cs rise
// ---------------------------------------------------------------------------
module spi_byte_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_cs,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   input  logic       spi_dc,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_dc
`ifdef ST7735_SPI_RX_STATS_EN
   ,
   output logic       trunc_pulse
`endif
);

   // Synchronizer lanes, packed as {cs, clk, mosi, dc}.
   localparam int LANE_CS   = 3;
   localparam int LANE_CLK  = 2;
   localparam int LANE_MOSI = 1;
   localparam int LANE_DC   = 0;
   localparam logic [3:0] SYNC_RESET = 4'b1000;  // cs idle high, rest low

   logic [3:0] sync_q [SYNC_STAGES];
   logic [3:0] sync_d [SYNC_STAGES];

   logic       sclk_prev_q, sclk_prev_d;
   logic       cs_prev_q, cs_prev_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic       byte_valid_q, byte_valid_d;
   logic [7:0] byte_data_q, byte_data_d;
   logic       byte_dc_q, byte_dc_d;

   logic cs_s, sclk_s, mosi_s, dc_s;
   logic sample, last_bit;

   assign cs_s   = sync_q[SYNC_STAGES-1][LANE_CS];
   assign sclk_s = sync_q[SYNC_STAGES-1][LANE_CLK];
   assign mosi_s = sync_q[SYNC_STAGES-1][LANE_MOSI];
   assign dc_s   = sync_q[SYNC_STAGES-1][LANE_DC];

   // Gating on the previous cs value lets a clock edge that lands together
   // with the cs rise still complete its byte.
   assign sample   = sclk_s & ~sclk_prev_q & ~cs_prev_q;
   assign last_bit = sample && (bit_cnt_q == 3'd7);

   always_comb begin
      sync_d[0] = {spi_cs, spi_clk, spi_mosi, spi_dc};
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before any branch so that no path
      // leaves it unassigned; a missing default here would infer a latch.
      sclk_prev_d  = sclk_s;
      cs_prev_d    = cs_s;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      byte_dc_d    = byte_dc_q;

      if (sample) begin
         shift_d   = {shift_q[5:0], mosi_s};
         bit_cnt_d = bit_cnt_q + 3'd1;  // 7 wraps to 0 on the last bit
      end
      if (last_bit) begin
         byte_valid_d = 1'b1;
         byte_data_d  = {shift_q, mosi_s};
         byte_dc_d    = dc_s;
      end
      if (cs_s) begin
         bit_cnt_d = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state is written only with non-blocking assignments
      // so every flop samples the pre-edge values of its neighbours.
      if (reset) begin
         // NOTE: the synchronizer array is reset explicitly; it is a chain of
         // individual flops, not a RAM, so a reset costs nothing and keeps
         // a stale pin value from producing an edge right after reset.
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= SYNC_RESET;
         end
         sclk_prev_q  <= 1'b0;
         cs_prev_q    <= 1'b1;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 7'd0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= 8'd0;
         byte_dc_q    <= 1'b0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         sclk_prev_q  <= sclk_prev_d;
         cs_prev_q    <= cs_prev_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
         byte_dc_q    <= byte_dc_d;
      end
   end

   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_data_q;
   assign byte_dc    = byte_dc_q;

`ifdef ST7735_SPI_RX_STATS_EN
   logic trunc_q, trunc_d;

   // A cs rise truncates when bits are pending or a non-final bit arrives
   // with it; a completing 8th bit is not a truncation.
   always_comb begin
      trunc_d = cs_s && !last_bit && ((bit_cnt_q != 3'd0) || sample);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         trunc_q <= 1'b0;
      end else begin
         trunc_q <= trunc_d;
      end
   end

   assign trunc_pulse = trunc_q;
`endif

endmodule : spi_byte_rx

// File: rtl/st7735_spi_rx.sv
// ---------------------------------------------------------------------------
// st7735_spi_rx
// Panel-side receiver for the 4-wire ST7735 SPI stream. Bytes from
// spi_byte_rx are decoded: CASET/RASET set the column/row window, RAMWR
// streams RGB565 pixels (high byte first) which are emitted with their
// (x, y) address. The address walks the window row by row and wraps.
//
// Optional macro ST7735_SPI_RX_STATS_EN enables saturating frame and
// truncation counters; without it frame_count/trunc_count are tied to 0.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   oled_cs/clk/mosi/dc     SPI pins (mode 0, cs active low, dc=1 data)
//   byte_valid/data/dc      raw byte strobe from the SPI receiver
//   pix_valid, pix_x/y      one-cycle pixel strobe and its address
//   pix_color               RGB565 colour
//   frame_done              strobe with the pixel at the window end
//   frame_count/trunc_count statistics (macro only, else 0)
// ---------------------------------------------------------------------------
module st7735_spi_rx
   import st7735_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int X_WIDTH     = 8,
   parameter int Y_WIDTH     = 7,
   parameter int COL_MAX     = 159,
   parameter int ROW_MAX     = 127
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               oled_cs,
   input  logic               oled_clk,
   input  logic               oled_mosi,
   input  logic               oled_dc,
   output logic               byte_valid,
   output logic [7:0]         byte_data,
   output logic               byte_dc,
   output logic               pix_valid,
   output logic [X_WIDTH-1:0] pix_x,
   output logic [Y_WIDTH-1:0] pix_y,
   output logic [15:0]        pix_color,
   output logic               frame_done,
   output logic [15:0]        frame_count,
   output logic [15:0]        trunc_count
);

   // Window parameters arrive as 16-bit big-endian values; only the low
   // AW bits of either axis are ever kept.
   localparam int AW = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;

`ifdef ST7735_SPI_RX_STATS_EN
   logic trunc_pulse;
`endif

   spi_byte_rx #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_byte_rx (
      .clk         (clk),
      .reset       (reset),
      .spi_cs      (oled_cs),
      .spi_clk     (oled_clk),
      .spi_mosi    (oled_mosi),
      .spi_dc      (oled_dc),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_dc     (byte_dc)
`ifdef ST7735_SPI_RX_STATS_EN
      ,
      .trunc_pulse (trunc_pulse)
`endif
   );

   rx_state_e          state_q, state_d;
   logic [1:0]         param_idx_q, param_idx_d;
   logic [AW-1:0]      acc_q, acc_d;      // low AW bits of the byte stream
   logic [AW-1:0]      start_q, start_d;  // start value held until byte 3
   logic [X_WIDTH-1:0] xs_q, xs_d, xe_q, xe_d, x_q, x_d;
   logic [Y_WIDTH-1:0] ys_q, ys_d, ye_q, ye_d, y_q, y_d;
   logic [7:0]         hi_q, hi_d;
   logic               half_q, half_d;
   logic               pix_valid_q, pix_valid_d;
   logic [X_WIDTH-1:0] pix_x_q, pix_x_d;
   logic [Y_WIDTH-1:0] pix_y_q, pix_y_d;
   rgb565_t            pix_color_q, pix_color_d;
   logic               frame_done_q, frame_done_d;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         param_idx_q  <= 2'd0;
         acc_q        <= '0;
         start_q      <= '0;
         xs_q         <= '0;
         xe_q         <= X_WIDTH'(COL_MAX);
         x_q          <= '0;
         ys_q         <= '0;
         ye_q         <= Y_WIDTH'(ROW_MAX);
         y_q          <= '0;
         hi_q         <= 8'd0;
         half_q       <= 1'b0;
         pix_valid_q  <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pix_color_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         param_idx_q  <= param_idx_d;
         acc_q        <= acc_d;
         start_q      <= start_d;
         xs_q         <= xs_d;
         xe_q         <= xe_d;
         x_q          <= x_d;
         ys_q         <= ys_d;
         ye_q         <= ye_d;
         y_q          <= y_d;
         hi_q         <= hi_d;
         half_q       <= half_d;
         pix_valid_q  <= pix_valid_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         pix_color_q  <= pix_color_d;
         frame_done_q <= frame_done_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      if (byte_valid) begin
         if (!byte_dc) begin
            case (byte_data)
               CMD_CASET: state_d = ST_CASET_P;
               CMD_RASET: state_d = ST_RASET_P;
               CMD_RAMWR: state_d = ST_RAMWR;
               default:   state_d = ST_IDLE;
            endcase
         end else if ((state_q == ST_CASET_P || state_q == ST_RASET_P) &&
                      param_idx_q == 2'd3) begin
            state_d = ST_IDLE;
         end
      end
   end

   // ---------------- output / datapath logic ----------------
   always_comb begin
      param_idx_d  = param_idx_q;
      acc_d        = acc_q;
      start_d      = start_q;
      xs_d         = xs_q;
      xe_d         = xe_q;
      x_d          = x_q;
      ys_d         = ys_q;
      ye_d         = ye_q;
      y_d          = y_q;
      hi_d         = hi_q;
      half_d       = half_q;
      pix_valid_d  = 1'b0;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      pix_color_d  = pix_color_q;
      frame_done_d = 1'b0;

      if (byte_valid) begin
         if (!byte_dc) begin
            param_idx_d = 2'd0;
            if (byte_data == CMD_RAMWR) begin
               x_d    = xs_q;
               y_d    = ys_q;
               half_d = 1'b0;
            end
         end else begin
            case (state_q)
               ST_CASET_P, ST_RASET_P: begin
                  acc_d       = AW'({acc_q, byte_data});
                  param_idx_d = param_idx_q + 2'd1;
                  if (param_idx_q == 2'd1) begin
                     start_d = acc_d;
                  end
                  if (param_idx_q == 2'd3) begin
                     if (state_q == ST_CASET_P) begin
                        xs_d = X_WIDTH'(start_q);
                        xe_d = X_WIDTH'(acc_d);
                     end else begin
                        ys_d = Y_WIDTH'(start_q);
                        ye_d = Y_WIDTH'(acc_d);
                     end
                  end
               end
               ST_RAMWR: begin
                  if (!half_q) begin
                     hi_d   = byte_data;
                     half_d = 1'b1;
                  end else begin
                     half_d       = 1'b0;
                     pix_valid_d  = 1'b1;
                     pix_x_d      = x_q;
                     pix_y_d      = y_q;
                     pix_color_d  = {hi_q, byte_data};
                     frame_done_d = (x_q == xe_q) && (y_q == ye_q);
                     // Equality (not >=) ends a row, so a window with
                     // start > end wraps through zero before reaching it.
                     if (x_q == xe_q) begin
                        x_d = xs_q;
                        y_d = (y_q == ye_q) ? ys_q : y_q + 1'b1;
                     end else begin
                        x_d = x_q + 1'b1;
                     end
                  end
               end
               default: ;  // data bytes in IDLE are ignored
            endcase
         end
      end
   end

   assign pix_valid  = pix_valid_q;
   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign pix_color  = pix_color_q;
   assign frame_done = frame_done_q;

`ifdef ST7735_SPI_RX_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] trunc_cnt_q, trunc_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      trunc_cnt_d = trunc_cnt_q;
      if (frame_done_d && frame_cnt_q != 16'hFFFF) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
      if (trunc_pulse && trunc_cnt_q != 16'hFFFF) begin
         trunc_cnt_d = trunc_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= 16'd0;
         trunc_cnt_q <= 16'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         trunc_cnt_q <= trunc_cnt_d;
      end
   end

   assign frame_count = frame_cnt_q;
   assign trunc_count = trunc_cnt_q;
`else
   assign frame_count = 16'd0;
   assign trunc_count = 16'd0;
`endif

endmodule : st7735_spi_rx

// File: tb/tb_st7735_spi_rx.sv
// ---------------------------------------------------------------------------
// tb_st7735_spi_rx
// Directed bench for st7735_spi_rx: bit-bangs SPI at clk/8, logs byte and
// pixel strobes on the falling clk edge and compares them against
// hand-computed expectations. Statistics expectations follow the
// ST7735_SPI_RX_STATS_EN macro.
// ---------------------------------------------------------------------------
module tb_st7735_spi_rx;

`ifdef ST7735_SPI_RX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        oled_cs, oled_clk, oled_mosi, oled_dc;
   logic        byte_valid, byte_dc, pix_valid, frame_done;
   logic [7:0]  byte_data;
   logic [7:0]  pix_x;
   logic [6:0]  pix_y;
   logic [15:0] pix_color, frame_count, trunc_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   st7735_spi_rx dut (
      .clk         (clk),
      .reset       (reset),
      .oled_cs     (oled_cs),
      .oled_clk    (oled_clk),
      .oled_mosi   (oled_mosi),
      .oled_dc     (oled_dc),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_dc     (byte_dc),
      .pix_valid   (pix_valid),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_color   (pix_color),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .trunc_count (trunc_count)
   );

   // ---------------- strobe logs ----------------
   int          byte_n = 0;
   logic [7:0]  last_byte = 8'h00;
   logic        last_dc = 1'b0;
   logic [7:0]  px_log [$];
   logic [6:0]  py_log [$];
   logic [15:0] pc_log [$];
   logic        fd_log [$];

   always @(negedge clk) begin
      if (byte_valid) begin
         byte_n++;
         last_byte = byte_data;
         last_dc   = byte_dc;
      end
      if (pix_valid) begin
         px_log.push_back(pix_x);
         py_log.push_back(pix_y);
         pc_log.push_back(pix_color);
         fd_log.push_back(frame_done);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      byte_n = 0;
      px_log.delete();
      py_log.delete();
      pc_log.delete();
      fd_log.delete();
   endtask

   task automatic cs_low();
      oled_cs = 1'b0;
      tick(4);
   endtask

   task automatic cs_high();
      tick(4);
      oled_cs = 1'b1;
      tick(10);
   endtask

   // Mode 0: data changes while sclk is low, 4 clk low + 4 clk high per bit.
   task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         oled_mosi = b[7-i];
         oled_dc   = dc;
         oled_clk  = 1'b0;
         tick(4);
         oled_clk  = 1'b1;
         tick(4);
      end
      oled_clk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic dc, input bit toggle);
      if (toggle) cs_low();
      send_bits(b, dc, 8);
      if (toggle) cs_high();
   endtask

   task automatic send_window_frame(input bit toggle);
      logic [7:0] caset [5];
      logic [7:0] raset [5];
      caset = '{8'h2A, 8'h00, 8'h02, 8'h00, 8'h04};
      raset = '{8'h2B, 8'h00, 8'h0A, 8'h00, 8'h0B};
      if (!toggle) cs_low();
      for (int i = 0; i < 5; i++) send_byte(caset[i], i != 0, toggle);
      for (int i = 0; i < 5; i++) send_byte(raset[i], i != 0, toggle);
      send_byte(8'h2C, 1'b0, toggle);
      for (int p = 0; p < 6; p++) begin
         send_byte(8'hA0 + 8'(p), 1'b1, toggle);
         send_byte(8'h50 + 8'(p), 1'b1, toggle);
      end
      if (!toggle) cs_high();
   endtask

   task automatic check_window_frame(input string pre);
      int ex_x [6];
      int ex_y [6];
      ex_x = '{2, 3, 4, 2, 3, 4};
      ex_y = '{10, 10, 10, 11, 11, 11};
      check({pre, "_npix"}, px_log.size(), 6);
      if (px_log.size() == 6) begin
         for (int p = 0; p < 6; p++) begin
            check($sformatf("%s_x%0d", pre, p), px_log[p], ex_x[p]);
            check($sformatf("%s_y%0d", pre, p), py_log[p], ex_y[p]);
            check($sformatf("%s_c%0d", pre, p), pc_log[p], {8'hA0 + 8'(p), 8'h50 + 8'(p)});
            check($sformatf("%s_fd%0d", pre, p), fd_log[p], p == 5);
         end
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset     = 1'b1;
      oled_cs   = 1'b1;
      oled_clk  = 1'b0;
      oled_mosi = 1'b0;
      oled_dc   = 1'b0;
      tick(4);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_byte_data", byte_data, 0);
      check("rst_pix_color", pix_color, 0);
      reset = 1'b0;
      tick(1);
      check("post_rst_byte_valid", byte_valid, 0);
      check("post_rst_pix_valid", pix_valid, 0);
      check("post_rst_frame_done", frame_done, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_trunc_count", trunc_count, 0);
      tick(4);

      // T1: single red pixel in the default window.
      clear_logs();
      cs_low();
      send_byte(8'h2C, 1'b0, 1'b0);
      send_byte(8'hF8, 1'b1, 1'b0);
      send_byte(8'h00, 1'b1, 1'b0);
      cs_high();
      check("t1_npix", px_log.size(), 1);
      if (px_log.size() == 1) begin
         check("t1_x", px_log[0], 0);
         check("t1_y", py_log[0], 0);
         check("t1_color", pc_log[0], 16'hF800);
         check("t1_fd", fd_log[0], 0);
      end
      check("t1_frame_count", frame_count, 0);
      check("t1_nbytes", byte_n, 3);

      // T2: 3x2 window, cs held low.
      clear_logs();
      send_window_frame(1'b0);
      check_window_frame("t2");
      check("t2_frame_count", frame_count, STATS ? 1 : 0);
      check("t2_trunc_count", trunc_count, 0);

      // T3: same frame with cs toggled around every byte.
      clear_logs();
      send_window_frame(1'b1);
      check_window_frame("t3");
      check("t3_frame_count", frame_count, STATS ? 2 : 0);
      check("t3_trunc_count", trunc_count, 0);

      // T4: 5-bit truncated byte then a full RAMWR command.
      clear_logs();
      cs_low();
      send_bits(8'hA5, 1'b1, 5);
      cs_high();
      check("t4_partial_nbytes", byte_n, 0);
      cs_low();
      send_byte(8'h2C, 1'b0, 1'b0);
      cs_high();
      check("t4_nbytes", byte_n, 1);
      check("t4_byte", last_byte, 8'h2C);
      check("t4_dc", last_dc, 0);
      check("t4_trunc_count", trunc_count, STATS ? 1 : 0);

      // T5: orphan high byte dropped by an intervening command.
      clear_logs();
      cs_low();
      send_byte(8'h2C, 1'b0, 1'b0);
      send_byte(8'hAA, 1'b1, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h2C, 1'b0, 1'b0);
      send_byte(8'h12, 1'b1, 1'b0);
      send_byte(8'h34, 1'b1, 1'b0);
      cs_high();
      check("t5_npix", px_log.size(), 1);
      if (px_log.size() == 1) begin
         check("t5_x", px_log[0], 2);
         check("t5_y", py_log[0], 10);
         check("t5_color", pc_log[0], 16'h1234);
      end

      // T6: reset between the two bytes of a pixel.
      cs_low();
      send_byte(8'h2C, 1'b0, 1'b0);
      send_byte(8'h55, 1'b1, 1'b0);
      tick(2);
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      clear_logs();
      tick(1);
      check("t6_post_rst_pix_valid", pix_valid, 0);
      check("t6_rst_frame_count", frame_count, 0);
      check("t6_rst_trunc_count", trunc_count, 0);
      send_byte(8'h2C, 1'b0, 1'b0);
      send_byte(8'h00, 1'b1, 1'b0);
      send_byte(8'h1F, 1'b1, 1'b0);
      cs_high();
      check("t6_npix", px_log.size(), 1);
      if (px_log.size() == 1) begin
         check("t6_x", px_log[0], 0);
         check("t6_y", py_log[0], 0);
         check("t6_color", pc_log[0], 16'h001F);
         check("t6_fd", fd_log[0], 0);
      end
      check("t6_trunc_count", trunc_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_st7735_spi_rx
